// File: rtl/non_res_div_param_if.sv
// Serial operand/result bus for the parametrised non-restoring divider.
// Clock and reset stay outside the interface as plain module ports.
interface non_res_div_param_if #(
   parameter int W = 8
);
   logic         begin_div;
   logic [W-1:0] in_bus;
   logic         busy;
   logic         fin;
   logic [W-1:0] out_bus;
   logic         dz;
   logic         ovf;

   modport master (
      output begin_div, in_bus,
      input  busy, fin, out_bus, dz, ovf
   );

   modport slave (
      input  begin_div, in_bus,
      output busy, fin, out_bus, dz, ovf
   );
endinterface

// File: rtl/non_res_div_param.sv
// Non-restoring divider: 2W-bit dividend / W-bit divisor, operands loaded serially,
// remainder then quotient returned serially, with divide-by-zero and overflow flags.
module non_res_div_param #(
   parameter int W = 8
) (
   input logic               clk,
   input logic               rst,
   non_res_div_param_if.slave bus
);
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [2:0] {
      IDLE, LD_Q, LD_M, CHECK, ITER, CORR, OUT_R, OUT_Q
   } state_t;

   state_t        state, state_n;
   logic [W:0]    a, a_n;
   logic [W-1:0]  q, q_n, m, m_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [W-1:0]  ob, ob_n;
   logic          fin_r, fin_n, dz_r, dz_n, ovf_r, ovf_n;

   logic [W:0]    m_ext, a_sh, a_step, a_corr;

   // A is signed W+1 bits; the shifted value may wrap, but add/sub of M brings it back in range
   always_comb begin
      m_ext  = {1'b0, m};
      a_sh   = {a[W-1:0], q[W-1]};
      a_step = a[W] ? (a_sh + m_ext) : (a_sh - m_ext);
      a_corr = a[W] ? (a + m_ext) : a;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a     <= '0;
         q     <= '0;
         m     <= '0;
         cnt   <= '0;
         ob    <= '0;
         fin_r <= 1'b0;
         dz_r  <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         state <= state_n;
         a     <= a_n;
         q     <= q_n;
         m     <= m_n;
         cnt   <= cnt_n;
         ob    <= ob_n;
         fin_r <= fin_n;
         dz_r  <= dz_n;
         ovf_r <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = a;
      q_n     = q;
      m_n     = m;
      cnt_n   = cnt;
      ob_n    = '0;
      fin_n   = 1'b0;
      dz_n    = dz_r;
      ovf_n   = ovf_r;
      unique case (state)
         IDLE: begin
            if (bus.begin_div) begin
               a_n     = {1'b0, bus.in_bus};
               state_n = LD_Q;
            end
         end
         LD_Q: begin
            q_n     = bus.in_bus;
            state_n = LD_M;
         end
         LD_M: begin
            m_n     = bus.in_bus;
            state_n = CHECK;
         end
         CHECK: begin
            // high word >= M means the quotient cannot fit in W bits
            if (m == '0) begin
               dz_n    = 1'b1;
               fin_n   = 1'b1;
               ob_n    = '1;
               state_n = OUT_R;
            end else if (a[W-1:0] >= m) begin
               ovf_n   = 1'b1;
               fin_n   = 1'b1;
               ob_n    = '1;
               state_n = OUT_R;
            end else begin
               cnt_n   = '0;
               state_n = ITER;
            end
         end
         ITER: begin
            a_n   = a_step;
            q_n   = {q[W-2:0], ~a_step[W]};
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(W - 1)) state_n = CORR;
         end
         CORR: begin
            a_n     = a_corr;
            fin_n   = 1'b1;
            ob_n    = a_corr[W-1:0];
            state_n = OUT_R;
         end
         OUT_R: begin
            fin_n   = 1'b1;
            ob_n    = (dz_r | ovf_r) ? '1 : q;
            state_n = OUT_Q;
         end
         OUT_Q: begin
            dz_n    = 1'b0;
            ovf_n   = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy    = (state != IDLE);
   assign bus.fin     = fin_r;
   assign bus.out_bus = ob;
   assign bus.dz      = dz_r;
   assign bus.ovf     = ovf_r;
endmodule

// File: doc/non_res_div_param.md
# non_res_div_param

Parametrised non-restoring divider with a W-bit operand bus. It divides a 2W-bit unsigned dividend by a W-bit unsigned divisor and returns a W-bit quotient and a W-bit remainder. Operands are loaded serially over `in_bus` and results are returned serially over `out_bus`, in the same style as the existing 8-bit divider datapath. Compared with that divider, this block adds a width parameter, divide-by-zero and quotient-overflow detection, a busy flag and a non-restoring final correction step.

## Interface
- `W`, default 8: operand/bus width; legal range W ≥ 2.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `begin_div`  in  1: start strobe; sampled only in IDLE.
- `in_bus`  in  W: operand bus.
- `busy`  out  1: high in every state except IDLE.
- `fin`  out  1: result-valid strobe; high for exactly 2 consecutive cycles per operation.
- `out_bus`  out  W: remainder in the first `fin` cycle, quotient in the second; registered.
- `dz`  out  1: divide-by-zero flag; valid while `fin` is high.
- `ovf`  out  1: quotient-overflow flag; valid while `fin` is high.

## Operation
- States: IDLE, LD_Q, LD_M, CHECK, ITER, CORR, OUT_R, OUT_Q.
- IDLE + `begin_div`=1:
  - Load A ← {1'b0, `in_bus`}; A is W+1 bits wide and holds the dividend high word.
  - Go to LD_Q.
- LD_Q: Q ← `in_bus` (dividend low word); go to LD_M.
- LD_M: M ← `in_bus` (divisor); go to CHECK.
- CHECK, first matching rule wins:
  - M==0: set `dz`; go to OUT_R.
  - A[W-1:0] ≥ M: the quotient does not fit in W bits. Set `ovf`; go to OUT_R.
  - Otherwise clear the counter; go to ITER.
- ITER, one step per cycle, W steps:
  - Shift {A,Q} left by 1.
  - If the old A sign bit was 0, A ← A − M; otherwise A ← A + M. Arithmetic is W+1 bits, two's complement, with M zero-extended.
  - Q[0] ← ~(new A sign bit).
  - Counter increments; after step W go to CORR.
- CORR: if the A sign bit is 1, A ← A + M; go to OUT_R.
- OUT_R:
  - `fin`=1.
  - `out_bus` = A[W-1:0] (remainder), or all ones if `dz` or `ovf` is set.
  - Go to OUT_Q.
- OUT_Q:
  - `fin`=1.
  - `out_bus` = Q (quotient), or all ones on error.
  - Clear `dz` and `ovf` on exit; go to IDLE.
- `begin_div` outside IDLE is ignored and has no effect on the operation in flight.
- `in_bus` is don't-care outside the IDLE-start, LD_Q and LD_M cycles.
- Counter width is $clog2(W)+1.

## Timing
- Reset values: state=IDLE; A, Q, M and counter = 0; `busy`=0, `fin`=0, `out_bus`=0, `dz`=0, `ovf`=0.
- Reset asserted mid-operation aborts immediately to the reset values; no `fin` is produced for the aborted operation.
- Edge numbering: edge 0 is the edge that samples `begin_div`. Loads take effect at edges 0, 1 and 2; CHECK is resolved at edge 3.
- Normal path:
  - Iterations at edges 4 .. W+3; correction at edge W+4.
  - `fin` is high during cycles W+5 and W+6: the cycle after edge W+4 shows the remainder, the next shows the quotient.
  - Total latency is W+6 cycles from edge 0 to the return to IDLE.
- Error path: `fin` is high in the 2 cycles after edge 3 (remainder slot then quotient slot), with `dz`/`ovf` held across both.
- `busy` rises on the cycle after edge 0 and falls when IDLE is re-entered.
- Back-to-back operation: a `begin_div` present in the first IDLE cycle after OUT_Q is accepted.

## Test plan
- W=8, `in_bus` sequence 0x00, 0x64, 0x07 → `out_bus` 0x02 then 0x0E; `dz`=`ovf`=0; `fin` high in cycles 13 and 14 after edge 0.
- W=8, operands 0x12, 0x34, 0x56 (4660/86) → 0x10 then 0x36.
- W=8, operands 0xFE, 0xFF, 0xFF (boundary: high word = M−1) → 0xFE then 0xFF; `ovf`=0.
- W=8, M=0x00, any dividend → `dz`=1 and 0xFF, 0xFF during the 2 `fin` cycles right after the CHECK edge. Also operands 0x10, 0x00, 0x08 → `ovf`=1 and 0xFF, 0xFF.
- Pulse `rst` during ITER of a 100/7 operation → all outputs 0 immediately, no `fin`. A following 100/7 run returns 0x02, 0x0E.
- W=16: dividend 0x0000_03E8 (high word 0x0000, low word 0x03E8 = 1000), divisor 0x0007 → 0x0006 then 0x008E. A `begin_div` pulse during ITER is ignored, and the result is unchanged.
